// File: rtl/ds_issue_pkg.sv
// Shared types and constants for the decode-stage issue controller.
// Holds default widths, the zero-register constant and the forward slot bundle.
package ds_issue_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  rdy;
    logic [AW_DEF-1:0]     waddr;
    logic [DATA_W_DEF-1:0] wdata;
  } fwd_slot_t;

endpackage

// File: rtl/ds_fwd_mux.sv
// Priority forward select for one source operand.
// Lowest slot index wins; r0 always reads zero.
module ds_fwd_mux
  import ds_issue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW = AW_DEF,
  parameter int NUM_FWD = 3
) (
  input  logic [AW-1:0]             raddr,
  input  logic                      use_src,
  input  logic [DATA_W-1:0]         rf_rdata,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*AW-1:0]     fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_rdy,
  input  logic                      sb_bit,
  input  logic                      long_hit,
  output logic [DATA_W-1:0]         data,
  output logic                      stall
);

  localparam logic [AW-1:0] RZ = AW'(ZERO_REG);

  logic win_rdy;

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    data = rf_rdata;
    win_rdy = 1'b1;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_we[i] &&
          fwd_waddr[i*AW +: AW] != RZ &&
          fwd_waddr[i*AW +: AW] == raddr) begin
        data = fwd_wdata[i*DATA_W +: DATA_W];
        win_rdy = fwd_rdy[i];
      end
    end
    if (raddr == RZ) begin
      data = '0;
    end
    stall = use_src & (~win_rdy | (sb_bit & ~long_hit));
  end

endmodule

// File: rtl/ds_issue_ctl.sv
// Decode-stage issue controller: ID valid, ID->EXE register, scoreboard.
// Optional DS_PERF_CNT_EN adds stall/bubble counters.
module ds_issue_ctl
  import ds_issue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW = AW_DEF,
  parameter int NUM_FWD = 3,
  parameter int PAY_W = 64,
  localparam int NREG = 1 << AW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      to_ds_valid,
  input  logic [PAY_W-1:0]          ds_in_pay,
  input  logic [AW-1:0]             ds_raddr1,
  input  logic [AW-1:0]             ds_raddr2,
  input  logic                      ds_use1,
  input  logic                      ds_use2,
  input  logic                      ds_rf_we,
  input  logic [AW-1:0]             ds_waddr,
  input  logic                      ds_is_long,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*AW-1:0]     fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_rdy,
  input  logic                      long_wb_valid,
  input  logic [AW-1:0]             long_wb_waddr,
  input  logic                      br_cancel,
  input  logic                      es_allow_in,
  output logic                      ds_valid,
  output logic                      ds_ready_go,
  output logic                      ds_allow_in,
  output logic [DATA_W-1:0]         op1,
  output logic [DATA_W-1:0]         op2,
  output logic                      es_valid,
  output logic [PAY_W-1:0]          es_pay,
  output logic [DATA_W-1:0]         es_src1,
  output logic [DATA_W-1:0]         es_src2,
  output logic                      es_rf_we,
  output logic [AW-1:0]             es_waddr,
  output logic [NREG-1:0]           sb_busy
`ifdef DS_PERF_CNT_EN
  ,
  output logic [31:0]               perf_stall,
  output logic [31:0]               perf_bubble
`endif
);

  localparam logic [AW-1:0] RZ = AW'(ZERO_REG);

  logic stall1, stall2, waw, hazard;
  logic issue, sb_set;
  logic hit1, hit2, hit_w;
  logic [NREG-1:0] sb_next;

  assign hit1 = long_wb_valid & (long_wb_waddr == ds_raddr1);
  assign hit2 = long_wb_valid & (long_wb_waddr == ds_raddr2);
  assign hit_w = long_wb_valid & (long_wb_waddr == ds_waddr);

  ds_fwd_mux #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .NUM_FWD(NUM_FWD)
  ) u_fwd1 (
    .raddr    (ds_raddr1),
    .use_src  (ds_use1),
    .rf_rdata (rf_rdata1),
    .fwd_valid(fwd_valid),
    .fwd_we   (fwd_we),
    .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata),
    .fwd_rdy  (fwd_rdy),
    .sb_bit   (sb_busy[ds_raddr1]),
    .long_hit (hit1),
    .data     (op1),
    .stall    (stall1)
  );

  ds_fwd_mux #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .NUM_FWD(NUM_FWD)
  ) u_fwd2 (
    .raddr    (ds_raddr2),
    .use_src  (ds_use2),
    .rf_rdata (rf_rdata2),
    .fwd_valid(fwd_valid),
    .fwd_we   (fwd_we),
    .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata),
    .fwd_rdy  (fwd_rdy),
    .sb_bit   (sb_busy[ds_raddr2]),
    .long_hit (hit2),
    .data     (op2),
    .stall    (stall2)
  );

  assign waw = ds_rf_we & ~ds_is_long & (ds_waddr != RZ)
             & sb_busy[ds_waddr] & ~hit_w;
  assign hazard = stall1 | stall2 | waw;
  assign ds_ready_go = ~hazard | ~ds_valid;
  assign ds_allow_in = ~ds_valid | (ds_ready_go & es_allow_in);
  assign issue = ds_valid & ds_ready_go & es_allow_in;
  assign sb_set = issue & ds_is_long & ds_rf_we & (ds_waddr != RZ);

  // Next scoreboard: clear on long write-back, a new producer wins.
  always_comb begin
    sb_next = sb_busy;
    if (long_wb_valid) begin
      sb_next[long_wb_waddr] = 1'b0;
    end
    if (sb_set) begin
      sb_next[ds_waddr] = 1'b1;
    end
  end

  // ID valid, EXE register and scoreboard state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid <= 1'b0;
      es_valid <= 1'b0;
      es_pay   <= '0;
      es_src1  <= '0;
      es_src2  <= '0;
      es_rf_we <= 1'b0;
      es_waddr <= '0;
      sb_busy  <= '0;
    end else begin
      if (br_cancel) begin
        ds_valid <= 1'b0;
      end else if (ds_allow_in) begin
        ds_valid <= to_ds_valid;
      end
      if (es_allow_in) begin
        es_valid <= ds_valid & ds_ready_go;
      end
      if (issue) begin
        es_pay   <= ds_in_pay;
        es_src1  <= op1;
        es_src2  <= op2;
        es_rf_we <= ds_rf_we;
        es_waddr <= ds_waddr;
      end
      sb_busy <= sb_next;
    end
  end

`ifdef DS_PERF_CNT_EN
  // Wrapping stall and bubble counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall  <= '0;
      perf_bubble <= '0;
    end else begin
      if (ds_valid & ~ds_ready_go) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (es_allow_in & ~issue) begin
        perf_bubble <= perf_bubble + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ds_issue_ctl.sv
// Randomized scoreboard bench for ds_issue_ctl.
// Reference model computes expected state per cycle from the issue rules.
module tb_ds_issue_ctl;

  localparam int DATA_W = 32;
  localparam int AW = 5;
  localparam int NUM_FWD = 3;
  localparam int PAY_W = 64;
  localparam int NREG = 32;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic reset;
  logic to_ds_valid;
  logic [PAY_W-1:0] ds_in_pay;
  logic [AW-1:0] ds_raddr1, ds_raddr2;
  logic ds_use1, ds_use2, ds_rf_we;
  logic [AW-1:0] ds_waddr;
  logic ds_is_long;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
  logic [NUM_FWD-1:0] fwd_valid, fwd_we, fwd_rdy;
  logic [NUM_FWD*AW-1:0] fwd_waddr;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
  logic long_wb_valid;
  logic [AW-1:0] long_wb_waddr;
  logic br_cancel, es_allow_in;
  logic ds_valid, ds_ready_go, ds_allow_in;
  logic [DATA_W-1:0] op1, op2;
  logic es_valid;
  logic [PAY_W-1:0] es_pay;
  logic [DATA_W-1:0] es_src1, es_src2;
  logic es_rf_we;
  logic [AW-1:0] es_waddr;
  logic [NREG-1:0] sb_busy;

  always #5 clk = ~clk;

  ds_issue_ctl #(
    .DATA_W(DATA_W), .AW(AW),
    .NUM_FWD(NUM_FWD), .PAY_W(PAY_W)
  ) dut (
    .clk(clk), .reset(reset),
    .to_ds_valid(to_ds_valid),
    .ds_in_pay(ds_in_pay),
    .ds_raddr1(ds_raddr1), .ds_raddr2(ds_raddr2),
    .ds_use1(ds_use1), .ds_use2(ds_use2),
    .ds_rf_we(ds_rf_we), .ds_waddr(ds_waddr),
    .ds_is_long(ds_is_long),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_rdy(fwd_rdy),
    .long_wb_valid(long_wb_valid),
    .long_wb_waddr(long_wb_waddr),
    .br_cancel(br_cancel), .es_allow_in(es_allow_in),
    .ds_valid(ds_valid), .ds_ready_go(ds_ready_go),
    .ds_allow_in(ds_allow_in),
    .op1(op1), .op2(op2),
    .es_valid(es_valid), .es_pay(es_pay),
    .es_src1(es_src1), .es_src2(es_src2),
    .es_rf_we(es_rf_we), .es_waddr(es_waddr),
    .sb_busy(sb_busy)
  );

  typedef struct {
    logic ds_valid;
    logic ready_go;
    logic allow_in;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic es_valid;
    logic [PAY_W-1:0] pay;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
    logic rf_we;
    logic [AW-1:0] waddr;
    logic [NREG-1:0] busy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Forward sources as plain arrays, packed onto the DUT ports.
  bit fv[NUM_FWD];
  bit fw[NUM_FWD];
  bit fr[NUM_FWD];
  int fa[NUM_FWD];
  logic [DATA_W-1:0] fd[NUM_FWD];

  // Reference model state.
  bit m_ds_valid;
  bit m_es_valid;
  logic [PAY_W-1:0] m_pay;
  logic [DATA_W-1:0] m_s1, m_s2;
  bit m_rf_we;
  int m_waddr;
  bit m_busy[NREG];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Operand resolution from the rules: first matching slot, else regfile.
  task automatic resolve(input int ra,
                         input logic [DATA_W-1:0] rf,
                         input bit lwv, input int lwa,
                         output logic [DATA_W-1:0] d,
                         output bit haz);
    int win;
    win = -1;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (fv[i] && fw[i] && fa[i] != 0 && fa[i] == ra) begin
        win = i;
        break;
      end
    end
    if (ra == 0) d = '0;
    else if (win < 0) d = rf;
    else d = fd[win];
    haz = (win >= 0 && !fr[win]) ||
          (m_busy[ra] && !(lwv && lwa == ra));
  endtask

  // Monitor: compare the DUT against the expected snapshot each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ds_valid", 64'(ds_valid), 64'(e.ds_valid));
        chk("ready_go", 64'(ds_ready_go), 64'(e.ready_go));
        chk("allow_in", 64'(ds_allow_in), 64'(e.allow_in));
        chk("op1", 64'(op1), 64'(e.op1));
        chk("op2", 64'(op2), 64'(e.op2));
        chk("es_valid", 64'(es_valid), 64'(e.es_valid));
        chk("es_pay", es_pay, e.pay);
        chk("es_src1", 64'(es_src1), 64'(e.s1));
        chk("es_src2", 64'(es_src2), 64'(e.s2));
        chk("es_rf_we", 64'(es_rf_we), 64'(e.rf_we));
        chk("es_waddr", 64'(es_waddr), 64'(e.waddr));
        chk("sb_busy", 64'(sb_busy), 64'(e.busy));
      end
    end
  end

  // Stimulus and reference model.
  initial begin
    bit prev_allow;
    bit h1, h2, waw, rg, ai, iss;
    logic [DATA_W-1:0] d1, d2;
    exp_t e;
    int wa, ra1, ra2, lwa;
    bit lwv;

    reset = 1'b1;
    to_ds_valid = 0; ds_in_pay = '0;
    ds_raddr1 = '0; ds_raddr2 = '0;
    ds_use1 = 0; ds_use2 = 0; ds_rf_we = 0;
    ds_waddr = '0; ds_is_long = 0;
    rf_rdata1 = '0; rf_rdata2 = '0;
    fwd_valid = '0; fwd_we = '0; fwd_rdy = '0;
    fwd_waddr = '0; fwd_wdata = '0;
    long_wb_valid = 0; long_wb_waddr = '0;
    br_cancel = 0; es_allow_in = 0;
    m_ds_valid = 0; m_es_valid = 0;
    m_pay = '0; m_s1 = '0; m_s2 = '0;
    m_rf_we = 0; m_waddr = 0;
    for (int r = 0; r < NREG; r++) m_busy[r] = 0;
    prev_allow = 1;

    #2;
    chk("rst_ds_valid", 64'(ds_valid), 64'd0);
    chk("rst_es_valid", 64'(es_valid), 64'd0);
    chk("rst_es_pay", es_pay, 64'd0);
    chk("rst_sb_busy", 64'(sb_busy), 64'd0);
    #10;
    reset = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (prev_allow) begin
        ds_in_pay = {$urandom(), $urandom()};
        ds_raddr1 = AW'($urandom_range(7));
        ds_raddr2 = AW'($urandom_range(7));
        ds_use1 = ($urandom_range(9) < 7);
        ds_use2 = ($urandom_range(9) < 6);
        ds_rf_we = ($urandom_range(9) < 7);
        ds_waddr = AW'($urandom_range(7));
        ds_is_long = ($urandom_range(9) < 2);
      end
      to_ds_valid = ($urandom_range(9) < 8);
      br_cancel = ($urandom_range(19) == 0);
      es_allow_in = ($urandom_range(9) < 8);
      rf_rdata1 = $urandom();
      rf_rdata2 = $urandom();
      for (int i = 0; i < NUM_FWD; i++) begin
        fv[i] = ($urandom_range(9) < 7);
        fw[i] = ($urandom_range(9) < 8);
        fr[i] = ($urandom_range(9) < 8);
        fa[i] = $urandom_range(7);
        fd[i] = $urandom();
        fwd_valid[i] = fv[i];
        fwd_we[i] = fw[i];
        fwd_rdy[i] = fr[i];
        fwd_waddr[i*AW +: AW] = AW'(fa[i]);
        fwd_wdata[i*DATA_W +: DATA_W] = fd[i];
      end
      lwa = $urandom_range(1, 7);
      lwv = m_busy[lwa] && ($urandom_range(2) == 0);
      long_wb_valid = lwv;
      long_wb_waddr = AW'(lwa);
      #1;

      ra1 = int'(ds_raddr1);
      ra2 = int'(ds_raddr2);
      wa = int'(ds_waddr);
      resolve(ra1, rf_rdata1, lwv, lwa, d1, h1);
      resolve(ra2, rf_rdata2, lwv, lwa, d2, h2);
      h1 = h1 && ds_use1;
      h2 = h2 && ds_use2;
      waw = ds_rf_we && !ds_is_long && wa != 0 &&
            m_busy[wa] && !(lwv && lwa == wa);
      rg = !m_ds_valid || !(h1 || h2 || waw);
      ai = !m_ds_valid || (rg && es_allow_in);
      iss = m_ds_valid && rg && es_allow_in;

      e.ds_valid = m_ds_valid;
      e.ready_go = rg;
      e.allow_in = ai;
      e.op1 = d1;
      e.op2 = d2;
      e.es_valid = m_es_valid;
      e.pay = m_pay;
      e.s1 = m_s1;
      e.s2 = m_s2;
      e.rf_we = m_rf_we;
      e.waddr = AW'(m_waddr);
      for (int r = 0; r < NREG; r++) e.busy[r] = m_busy[r];
      q.push_back(e);

      if (es_allow_in) m_es_valid = m_ds_valid && rg;
      if (iss) begin
        m_pay = ds_in_pay;
        m_s1 = d1;
        m_s2 = d2;
        m_rf_we = ds_rf_we;
        m_waddr = wa;
      end
      if (lwv) m_busy[lwa] = 0;
      if (iss && ds_is_long && ds_rf_we && wa != 0)
        m_busy[wa] = 1;
      if (br_cancel) m_ds_valid = 0;
      else if (ai) m_ds_valid = to_ds_valid;
      prev_allow = ai;
    end

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ds_valid", 64'(ds_valid), 64'd0);
    chk("arst_allow_in", 64'(ds_allow_in), 64'd1);
    chk("arst_es_valid", 64'(es_valid), 64'd0);
    chk("arst_es_pay", es_pay, 64'd0);
    chk("arst_es_src1", 64'(es_src1), 64'd0);
    chk("arst_es_src2", 64'(es_src2), 64'd0);
    chk("arst_es_rf_we", 64'(es_rf_we), 64'd0);
    chk("arst_es_waddr", 64'(es_waddr), 64'd0);
    chk("arst_sb_busy", 64'(sb_busy), 64'd0);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue: %0d left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
